hdlc_tx_framer: RTL

Transmit-side HDLC framer: serialises bytes from the Tx buffer into a bit stream on `Tx`, emitting opening and closing flags, zero-bit insertion, an optional FCS and abort patterns. Line idles at all ones. It is the counterpart of the Rx deframer, and its output feeds the Rx path directly in loopback benches.

---
 rtl/hdlc_tx_framer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: opening flags, zero-bit-stuffed data, optional CRC-16 FCS (HDLC_TX_FCS_EN), closing flag or abort.
// Latency: first flag bit on Tx the cycle after Tx_Start; each accepted byte's bit 0 goes out the cycle after the transfer.
// Backpressure: Tx_Ready is only offered in a byte's final bit-time; a missing byte aborts the frame with Tx_Underrun.
module hdlc_tx_framer #(
    parameter int FLAG_COUNT = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       TxEN,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Valid,
    input  logic       Tx_Last,
    output logic       Tx_Ready,
    input  logic       Tx_AbortFrame,
    output logic       Tx,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Underrun
);
    typedef enum logic [2:0] {
        IDLE, FLAG_OPEN, DATA,
`ifdef HDLC_TX_FCS_EN
        FCS,
`endif
        FLAG_CLOSE, ABORT
    } state_t;

    localparam logic [7:0] FlagPat  = 8'h7E;
    localparam logic [1:0] LastFlag = 2'(FLAG_COUNT - 1);

    state_t      state;
    logic [3:0]  bitIdx;     // index of the field bit currently on Tx
    logic [1:0]  flagNum;
    logic [2:0]  onesCnt;    // consecutive ones including the bit on Tx
    logic [15:0] shiftReg;
    logic        lastByte;
    logic        needByte;
    logic        abortReq;

    function automatic logic [2:0] nextOnes(input logic b, input logic [2:0] n);
        return b ? n + 3'd1 : 3'd0;
    endfunction

`ifdef HDLC_TX_FCS_EN
    logic [15:0] crc;

    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
        end
        return r;
    endfunction
`endif

    always_comb begin
        needByte = ((state == FLAG_OPEN) && (bitIdx == 4'd7) && (flagNum == LastFlag)) ||
                   ((state == DATA) && (bitIdx == 4'd7) && (onesCnt != 3'd5) && !lastByte);
        abortReq = ((state == FLAG_OPEN) || (state == DATA)
`ifdef HDLC_TX_FCS_EN
                    || (state == FCS)
`endif
                   ) && (Tx_AbortFrame || !TxEN);
        Tx_Ready = needByte && TxEN && !Tx_AbortFrame;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= IDLE;
            bitIdx          <= 4'd0;
            flagNum         <= 2'd0;
            onesCnt         <= 3'd0;
            shiftReg        <= 16'd0;
            lastByte        <= 1'b0;
            Tx              <= 1'b1;
            Tx_Busy         <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            Tx_Underrun     <= 1'b0;
`ifdef HDLC_TX_FCS_EN
            crc             <= 16'hFFFF;
`endif
        end else begin
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            Tx_Underrun     <= 1'b0;
            if (abortReq) begin
                state  <= ABORT;
                bitIdx <= 4'd0;
                Tx     <= 1'b0;
            end else if (needByte) begin
                if (Tx_Valid) begin
                    state    <= DATA;
                    shiftReg <= {8'h00, Tx_Data};
                    bitIdx   <= 4'd0;
                    Tx       <= Tx_Data[0];
                    lastByte <= Tx_Last;
                    onesCnt  <= nextOnes(Tx_Data[0], (state == FLAG_OPEN) ? 3'd0 : onesCnt);
`ifdef HDLC_TX_FCS_EN
                    crc      <= crcByte(crc, Tx_Data);
`endif
                end else begin
                    state       <= ABORT;
                    bitIdx      <= 4'd0;
                    Tx          <= 1'b0;
                    Tx_Underrun <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        Tx <= 1'b1;
                        if (Tx_Start && TxEN) begin
                            state    <= FLAG_OPEN;
                            bitIdx   <= 4'd0;
                            flagNum  <= 2'd0;
                            onesCnt  <= 3'd0;
                            lastByte <= 1'b0;
                            Tx       <= 1'b0;
                            Tx_Busy  <= 1'b1;
`ifdef HDLC_TX_FCS_EN
                            crc      <= 16'hFFFF;
`endif
                        end
                    end
                    FLAG_OPEN: begin
                        if (bitIdx == 4'd7) begin
                            flagNum <= flagNum + 2'd1;
                            bitIdx  <= 4'd0;
                            Tx      <= 1'b0;
                        end else begin
                            bitIdx <= bitIdx + 4'd1;
                            Tx     <= FlagPat[bitIdx[2:0] + 3'd1];
                        end
                    end
                    DATA: begin
                        if (onesCnt == 3'd5) begin
                            Tx      <= 1'b0;
                            onesCnt <= 3'd0;
                        end else if (bitIdx == 4'd7) begin
`ifdef HDLC_TX_FCS_EN
                            state    <= FCS;
                            shiftReg <= ~crc;
                            bitIdx   <= 4'd0;
                            Tx       <= ~crc[0];
                            onesCnt  <= nextOnes(~crc[0], onesCnt);
`else
                            state  <= FLAG_CLOSE;
                            bitIdx <= 4'd0;
                            Tx     <= 1'b0;
`endif
                        end else begin
                            bitIdx  <= bitIdx + 4'd1;
                            Tx      <= shiftReg[bitIdx + 4'd1];
                            onesCnt <= nextOnes(shiftReg[bitIdx + 4'd1], onesCnt);
                        end
                    end
`ifdef HDLC_TX_FCS_EN
                    FCS: begin
                        if (onesCnt == 3'd5) begin
                            Tx      <= 1'b0;
                            onesCnt <= 3'd0;
                        end else if (bitIdx == 4'd15) begin
                            state  <= FLAG_CLOSE;
                            bitIdx <= 4'd0;
                            Tx     <= 1'b0;
                        end else begin
                            bitIdx  <= bitIdx + 4'd1;
                            Tx      <= shiftReg[bitIdx + 4'd1];
                            onesCnt <= nextOnes(shiftReg[bitIdx + 4'd1], onesCnt);
                        end
                    end
`endif
                    FLAG_CLOSE: begin
                        if (bitIdx == 4'd7) begin
                            state   <= IDLE;
                            Tx      <= 1'b1;
                            Tx_Busy <= 1'b0;
                            Tx_Done <= 1'b1;
                        end else begin
                            bitIdx <= bitIdx + 4'd1;
                            Tx     <= FlagPat[bitIdx[2:0] + 3'd1];
                        end
                    end
                    ABORT: begin
                        if (bitIdx == 4'd7) begin
                            state           <= IDLE;
                            Tx              <= 1'b1;
                            Tx_Busy         <= 1'b0;
                            Tx_AbortedTrans <= 1'b1;
                        end else begin
                            bitIdx <= bitIdx + 4'd1;
                            Tx     <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
